// File: rtl/hk_spi_pkg.sv
// Shared definitions for the housekeeping SPI slave: command fields,
// stream command constants and the transfer state encoding.
package hk_spi_pkg;

  localparam int CMD_WR_BIT = 7;
  localparam int CMD_RD_BIT = 6;
  localparam int CMD_CNT_HI = 5;
  localparam int CMD_CNT_LO = 3;

  localparam logic [7:0] CMD_READ_STREAM  = 8'h40;
  localparam logic [7:0] CMD_WRITE_STREAM = 8'h80;
  localparam logic [7:0] CMD_RW_STREAM    = 8'hC0;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE
  } state_e;

  // A command is usable only if it reads and/or writes and its low bits are clear.
  function automatic logic cmd_valid(input logic [7:0] cmd);
    return (cmd[CMD_WR_BIT:CMD_RD_BIT] != 2'b00) && (cmd[2:0] == 3'b000);
  endfunction

endpackage

// File: rtl/hk_spi_sync.sv
// Oversampling front end: synchronises SCK/CSB/SDI into the system clock
// domain and produces registered edge pulses aligned with the sampled SDI.
module hk_spi_sync
  import hk_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic spi_sck,
  input  logic spi_csb,
  input  logic spi_sdi,
  output logic sck_rise,
  output logic sck_fall,
  output logic csb_fall,
  output logic csb_s,
  output logic sdi_s
);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_csb_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic [SYNC_STAGES-1:0] r_flush;
  logic                   r_sck_d;
  logic                   r_csb_d;
  logic                   r_csb_armed;
  logic                   r_sck_rise;
  logic                   r_sck_fall;
  logic                   r_csb_fall;
  logic                   r_sdi_d;
  logic                   w_sck_s;
  logic                   w_csb_s;
  logic                   w_sdi_s;

  assign w_sck_s = r_sck_sync[SYNC_STAGES-1];
  assign w_csb_s = r_csb_sync[SYNC_STAGES-1];
  assign w_sdi_s = r_sdi_sync[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, giving a true shift chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sck_sync  <= '0;
      r_csb_sync  <= '1;
      r_sdi_sync  <= '0;
      r_flush     <= '0;
      r_sck_d     <= 1'b0;
      r_csb_d     <= 1'b1;
      r_csb_armed <= 1'b0;
      r_sck_rise  <= 1'b0;
      r_sck_fall  <= 1'b0;
      r_csb_fall  <= 1'b0;
      r_sdi_d     <= 1'b0;
    end else begin
      r_sck_sync[0] <= spi_sck;
      r_csb_sync[0] <= spi_csb;
      r_sdi_sync[0] <= spi_sdi;
      r_flush[0]    <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sck_sync[i] <= r_sck_sync[i-1];
        r_csb_sync[i] <= r_csb_sync[i-1];
        r_sdi_sync[i] <= r_sdi_sync[i-1];
        r_flush[i]    <= r_flush[i-1];
      end
      r_sck_d    <= w_sck_s;
      r_csb_d    <= w_csb_s;
      r_sdi_d    <= w_sdi_s;
      r_sck_rise <= w_sck_s & ~r_sck_d;
      r_sck_fall <= ~w_sck_s & r_sck_d;
      // CSB held low through reset must be seen high before a fall counts.
      r_csb_armed <= r_csb_armed | (r_flush[SYNC_STAGES-1] & w_csb_s);
      r_csb_fall  <= ~w_csb_s & r_csb_d & r_csb_armed;
    end
  end

  assign sck_rise = r_sck_rise;
  assign sck_fall = r_sck_fall;
  assign csb_fall = r_csb_fall;
  assign csb_s    = w_csb_s;
  assign sdi_s    = r_sdi_d;

endmodule

// File: rtl/hk_spi_slave.sv
// Housekeeping SPI slave: decodes command/address/data bytes into register
// read/write strobes. Define HK_SPI_NBYTE_EN to honour the cmd[5:3] byte count.
module hk_spi_slave
  import hk_spi_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_csb,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdoenb,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  state_e            r_state;
  state_e            w_next_state;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_rx_shift;
  logic [7:0]        r_cmd;
  logic [7:0]        r_tx_shift;
  logic [7:0]        r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic              r_re;
  logic              r_inc_pend;
  logic              r_load;
  logic              w_sck_rise;
  logic              w_unused_sck_fall;
  logic              w_csb_fall;
  logic              w_csb_s;
  logic              w_sdi_s;
  logic              w_active;
  logic              w_byte_done;
  logic              w_last;
  logic [7:0]        w_rx_byte;

  hk_spi_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset   (reset),
    .spi_sck (spi_sck),
    .spi_csb (spi_csb),
    .spi_sdi (spi_sdi),
    .sck_rise(w_sck_rise),
    .sck_fall(w_unused_sck_fall),
    .csb_fall(w_csb_fall),
    .csb_s   (w_csb_s),
    .sdi_s   (w_sdi_s)
  );

  assign w_rx_byte   = {r_rx_shift[6:0], w_sdi_s};
  assign w_byte_done = w_active & w_sck_rise & (r_bit_cnt == 3'd7) & ~w_csb_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path leaves the next state unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_csb_fall) w_next_state = CMD;
      CMD:     if (w_byte_done) w_next_state = cmd_valid(w_rx_byte) ? ADDR : DONE;
      ADDR:    if (w_byte_done) w_next_state = DATA;
      DATA:    if (w_byte_done && w_last) w_next_state = DONE;
      default: w_next_state = r_state;
    endcase
    if (w_csb_s) w_next_state = IDLE;
  end

  always_comb begin
    w_active   = (r_state == CMD) || (r_state == ADDR) || (r_state == DATA);
    spi_sdoenb = !((r_state == DATA) && r_cmd[CMD_RD_BIT]);
    busy       = ~w_csb_s;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_cmd      <= '0;
      r_tx_shift <= '0;
      r_wdata    <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_inc_pend <= 1'b0;
      r_load     <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_inc_pend <= 1'b0;
      r_load     <= r_re;

      if (w_csb_s || (r_state == IDLE)) begin
        r_bit_cnt <= '0;
      end else if (w_active && w_sck_rise) begin
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_rx_shift <= w_rx_byte;
      end

      if (w_byte_done) begin
        case (r_state)
          CMD:  r_cmd <= w_rx_byte;
          ADDR: begin
            r_addr <= ADDR_W'(w_rx_byte);
            r_re   <= r_cmd[CMD_RD_BIT];
          end
          DATA: begin
            if (r_cmd[CMD_WR_BIT]) begin
              // Write lands first; the increment and prefetch follow next cycle.
              r_wdata    <= w_rx_byte;
              r_we       <= 1'b1;
              r_inc_pend <= 1'b1;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
              r_re   <= r_cmd[CMD_RD_BIT] & ~w_last;
            end
          end
          default: ;
        endcase
      end

      if (r_inc_pend) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_re   <= r_cmd[CMD_RD_BIT] & (r_state == DATA);
      end

      if (r_load)          r_tx_shift <= reg_rdata;
      else if (w_sck_rise) r_tx_shift <= {r_tx_shift[6:0], 1'b0};
    end
  end

`ifdef HK_SPI_NBYTE_EN
  logic [2:0] r_remain;
  logic       r_cnt_on;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_remain <= '0;
      r_cnt_on <= 1'b0;
    end else if (r_state == IDLE) begin
      r_cnt_on <= 1'b0;
    end else if (w_byte_done && (r_state == CMD)) begin
      r_remain <= w_rx_byte[CMD_CNT_HI:CMD_CNT_LO];
      r_cnt_on <= (w_rx_byte[CMD_CNT_HI:CMD_CNT_LO] != 3'd0);
    end else if (w_byte_done && (r_state == DATA) && r_cnt_on) begin
      r_remain <= r_remain - 3'd1;
    end
  end

  assign w_last = r_cnt_on && (r_remain == 3'd1);
`else
  assign w_last = 1'b0;
`endif

  assign spi_sdo   = r_tx_shift[7];
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = r_re;

endmodule

// File: doc/hk_spi_slave.md
# hk_spi_slave

Housekeeping SPI slave front-end that decodes the command/address/data byte stream a host drives on the housekeeping pins (SCK, CSB, SDI, SDO on mprj_io[4:1]) into single-cycle register read/write strobes for the housekeeping register file. SPI pins are oversampled in the system clock domain. The block sits between the pad-side SPI pins and the housekeeping register bank, which supplies read data for the SDO path.

## Interface
Parameters:
- ADDR_W, 8, register address width; the address wraps modulo 2^ADDR_W.
- SYNC_STAGES, 2, synchroniser depth on SCK, CSB and SDI.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- spi_sck  in  1  SPI clock, mode 0.
- spi_csb  in  1  chip select, active-low.
- spi_sdi  in  1  serial data in, MSB first.
- spi_sdo  out  1  serial data out, MSB first.
- spi_sdoenb  out  1  SDO output enable, active-low.
- reg_addr  out  ADDR_W  register address.
- reg_wdata  out  8  write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data, valid one cycle after reg_re.
- busy  out  1  high while synchronised CSB is low.

## Operation
- SCK, CSB and SDI each pass through SYNC_STAGES flops.
- Edge detect on synchronised SCK produces sck_rise and sck_fall.
- SDI is sampled on sck_rise.
- A bit counter (3 bits) counts sck_rise events. A byte completes on the 8th rise.
- State machine:
  - IDLE: waiting for CSB. Synchronised CSB falling → CMD.
  - CMD: on byte complete, latch cmd.
    - cmd[7:6]=00, or cmd[2:0]≠000 → DONE.
    - Otherwise → ADDR.
  - ADDR: on byte complete, latch reg_addr.
    - If cmd[6]=1 (read), pulse reg_re.
    - Then → DATA.
  - DATA: on byte complete:
    - If cmd[7]=1 (write), drive reg_wdata and pulse reg_we at the current address.
    - Then increment reg_addr.
    - If cmd[6]=1, pulse reg_re at the new address (prefetch).
    - Decrement the remaining-byte count if it is active.
  - DONE: all further SCK activity is ignored.
- CSB high, synchronised, in any state → IDLE immediately. A partial byte is discarded with no strobe.
- Command encoding: cmd[7] = write, cmd[6] = read, cmd[5:3] = byte count n (0 means unlimited stream).
  - 0x40 = read stream.
  - 0x80 = write stream.
  - 0xC0 = simultaneous read/write.
- The transmit shift register loads reg_rdata on the cycle after reg_re.
- spi_sdo = tx_shift[7]. The register shifts left on every sck_rise that is not a load cycle.
- spi_sdoenb is low only in DATA with cmd[6]=1; otherwise it is high.
- reg_addr increments by 1 and wraps from 0xFF to 0x00.

## Timing
- Reset values:
  - spi_sdo=0, spi_sdoenb=1.
  - reg_addr=0, reg_wdata=0.
  - reg_we=0, reg_re=0, busy=0.
  - State = IDLE.
- Latency from a real SCK edge to the detected edge is SYNC_STAGES+1 clocks.
- reg_we and reg_re assert one clock after the detected 8th sck_rise. Each is high for exactly one cycle.
- New SDO bit is valid SYNC_STAGES+2 clocks after the SCK rise. This is within the SCK high phase, so it is valid before the next fall.
- Host constraints: SCK high ≥ SYNC_STAGES+3 clocks; SCK low ≥ SYNC_STAGES+1 clocks.
- At the bench setting (20 ns clock, 100 ns SCK phases), both constraints are met.
- On CSB deassert, spi_sdoenb goes high within SYNC_STAGES+1 clocks.
- reg_we and reg_re never assert in the same cycle for different addresses.
  - In read/write mode, the write to addr N precedes the read prefetch of N+1 by one cycle.
- Async reset mid-transfer clears everything at once. The next transfer requires a fresh CSB fall.

## Configuration
- HK_SPI_NBYTE_EN defined:
  - cmd[5:3]=n≠0 loads the remaining-byte count with n.
  - After n DATA bytes → DONE, with no further strobes.
- HK_SPI_NBYTE_EN undefined:
  - cmd[5:3] is ignored and every command streams until CSB rises.
  - The counter logic is not instantiated.

## Structure
- hk_spi_pkg holds:
  - The command bit positions and the CMD_READ_STREAM, CMD_WRITE_STREAM and CMD_RW_STREAM constants.
  - The state enum (IDLE, CMD, ADDR, DATA, DONE).
- Sub-module hk_spi_sync contains the synchroniser flops plus the sck_rise, sck_fall and csb_fall detection. hk_spi_slave instantiates it once.

## Test plan
- Register-file model with addr3=0x11. Send 0x40, 0x03, then read 1 byte → SDO byte 0x11; reg_re at addr 0x03, then at 0x04 (prefetch).
- Send 0x80, 0x0B, 0x01, raise CSB, then 0x80, 0x0B, 0x00 → exactly two reg_we, at addr 0x0B with data 0x01 and then 0x00.
- Send 0x40, 0x00, then read 19 bytes → reg_re at addresses 0x00–0x13. Read bytes match the model (0x00, 0x04, 0x56, 0x11, …, 0x04).
- With HK_SPI_NBYTE_EN, send 0x90, 0x10, 0xAA, 0xBB, 0xCC → reg_we at 0x10/0xAA and 0x11/0xBB only. Without the macro, a third write at 0x12/0xCC.
- Send 0x80, 0xFF, 0x5A, 0xA5 → writes 0xFF←0x5A and then 0x00←0xA5 (address wrap).
- Send 0x80, 0x20, then 4 data bits and raise CSB → no reg_we; spi_sdoenb=1 and busy=0 within 3 clocks. Assert reset mid-byte in a second pass → all outputs at reset values. The next transaction works normally.
